// File: rtl/wb_timer.sv
// Wishbone classic 32-bit timer for the picorv32 SoC: programmable prescaler,
// compare match with optional auto-reload, sticky pending flag and level irq.
module wb_timer #(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [31:0] COMPARE_RESET  = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        irq_o
);

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_PRESCALE = 3'd1;
  localparam logic [2:0] IDX_COUNT    = 3'd2;
  localparam logic [2:0] IDX_COMPARE  = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [2:0]                ctrl_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] pcnt_q;
  logic [31:0]               count_q;
  logic [31:0]               compare_q;
  logic                      pend_q;

  logic        req, wr, en, tick, count_wr, match, status_clr;
  logic [2:0]  idx;
  logic [31:0] prescale_ext, prescale_wr, rdata;
  logic        unused_adr_bits;

  // Only the word index is decoded; the rest of the address is don't-care.
  assign unused_adr_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  assign idx          = wb_adr_i[4:2];
  assign req          = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr           = req & wb_we_i;
  assign en           = ctrl_q[0];
  assign tick         = en & (pcnt_q == prescale_q);
  assign count_wr     = wr & (idx == IDX_COUNT);
  // A bus write to COUNT pre-empts the tick entirely, including the compare.
  assign match        = tick & ~count_wr & (count_q == compare_q);
  assign status_clr   = wr & (idx == IDX_STATUS) & wb_sel_i[0] & wb_dat_i[0];
  assign prescale_ext = 32'(prescale_q);
  assign prescale_wr  = merge_bytes(prescale_ext, wb_dat_i, wb_sel_i);

  assign wb_err_o = 1'b0;
  assign irq_o    = pend_q & ctrl_q[2];

  always_comb begin
    // NOTE: default first so every path assigns rdata and no latch is inferred.
    rdata = '0;
    case (idx)
      IDX_CTRL:     rdata = {29'd0, ctrl_q};
      IDX_PRESCALE: rdata = prescale_ext;
      IDX_COUNT:    rdata = count_q;
      IDX_COMPARE:  rdata = compare_q;
      IDX_STATUS:   rdata = {31'd0, pend_q};
      default:      rdata = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      compare_q  <= COMPARE_RESET;
    end else if (wr) begin
      if (idx == IDX_CTRL && wb_sel_i[0]) ctrl_q <= wb_dat_i[2:0];
      if (idx == IDX_PRESCALE) prescale_q <= prescale_wr[PRESCALE_WIDTH-1:0];
      if (idx == IDX_COMPARE) compare_q <= merge_bytes(compare_q, wb_dat_i, wb_sel_i);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pcnt_q <= '0;
    end else if ((wr && idx == IDX_PRESCALE) || tick || !en) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      if (count_wr) begin
        count_q <= merge_bytes(count_q, wb_dat_i, wb_sel_i);
      end else if (tick) begin
        count_q <= (match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
      end
      // Setting wins over a simultaneous write-1-to-clear.
      if (match) pend_q <= 1'b1;
      else if (status_clr) pend_q <= 1'b0;
    end
  end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone classic responder that gives the picorv32 initiator a memory-mapped 32-bit timer.
- Provides a programmable prescaler, a compare register and a level interrupt.
- Sits on the SoC intercon as a slave beside sram0, rom0 and uart0.
- The CPU uses it for delays and periodic interrupts.

Parameters:
- PRESCALE_WIDTH, 16: width of the PRESCALE register and the internal prescale counter.
- COMPARE_RESET, 32'hFFFF_FFFF: reset value of the COMPARE register.

Ports:
- wb_clk_i  in  1  system clock; all logic is on the rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  byte address; only [4:2] is decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane enables for writes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  tied 0.
- irq_o  out  1  timer interrupt, level.

Behaviour:
- Reset (wb_rst_ni low, async):
  - wb_ack_o=0, wb_dat_o=0.
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=COMPARE_RESET, STATUS.pend=0.
  - Prescale counter pcnt=0, irq_o=0.
- Register map (index wb_adr_i[4:2]):
  - 0 CTRL: [0] en, [1] autoreload, [2] irq_en; other bits read 0.
  - 1 PRESCALE: [PRESCALE_WIDTH-1:0].
  - 2 COUNT: 32-bit.
  - 3 COMPARE: 32-bit.
  - 4 STATUS: [0] pend; write 1 to clear.
  - 5-7: read 0, writes ignored, still acked.
- Handshake:
  - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o is registered: high exactly one cycle after a request, then low for at least one cycle.
  - Back-to-back accesses therefore take 2 cycles each.
  - wb_dat_o is registered in the same edge as ack; it is 0 whenever ack is low.
  - Writes commit on the edge that raises ack.
  - Each byte lane is written only where wb_sel_i[n]=1.
  - If cyc drops before ack, no ack is generated for the aborted request.
- Prescaler:
  - tick = en & (pcnt == PRESCALE).
  - On tick pcnt<=0; else if en, pcnt<=pcnt+1.
  - en=0 holds pcnt at 0.
  - Any write to PRESCALE clears pcnt.
  - PRESCALE=N gives one tick per N+1 cycles; N=0 ticks every cycle.
- Counter on tick:
  - If COUNT==COMPARE: pend<=1; then COUNT<=0 if autoreload, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Wraps at 32'hFFFF_FFFF to 0 with no flag.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the bus value wins, and the tick neither increments nor matches.
  - STATUS W1C in the same cycle as a match set: the set wins, pend stays 1.
  - Write to COMPARE takes effect on the next tick evaluation.
- irq_o = pend & irq_en, combinational from registers, no extra latency.
- Reset mid-transaction: ack drops immediately; the master must restart the access.

Test Plan:
- Reset then read all regs → CTRL=0, PRESCALE=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0, idx 5 reads 0; every access gets exactly one ack, one cycle after stb.
- PRESCALE=3, CTRL=1, wait 40 cycles then read COUNT → value within ±1 of 10; with PRESCALE=0, COUNT advances 1 per cycle.
- COMPARE=5, CTRL=7 (en, autoreload, irq_en), PRESCALE=0 → pend and irq_o rise the cycle COUNT==5 is ticked; COUNT goes 5→0; W1C STATUS=1 drops irq_o next cycle.
- COUNT=FFFF_FFFE, COMPARE=10, CTRL=1 → COUNT reads 0 two ticks later; pend stays 0.
- Byte-lane write: COMPARE=0, then write 0xAABBCCDD with sel=4'b0101 → COMPARE reads 0x00BB00DD.
- Write COUNT=100 coinciding with a tick, then STATUS W1C coinciding with a match → COUNT=100 (then 101 on the next tick); pend=1; assert wb_rst_ni low mid-access → all outputs 0 immediately.
